// File: rtl/fft_trim_pkg.sv
// Shared types and constants for the FFT output trimming controller.
package fft_trim_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_e;

    // Side of the full input array for a given trimmed window side.
    function automatic int full_side(input int size);
        return 2 * size - 1;
    endfunction

    // First kept row/column index inside the full array.
    function automatic int trim_off(input int size);
        return (size - 1) - (size - 1) / 2;
    endfunction

endpackage

// File: rtl/fft_trim_ctrl_idx_cnt.sv
// Row/column raster counter over an N x N array with synchronous clear,
// count enable and wrap of both indices.
module trim_idx_cnt #(
    parameter int N = 9,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] row_o,
    output logic [W-1:0] col_o,
    output logic         last_o
);

    logic [W-1:0] row_q, row_d;
    logic [W-1:0] col_q, col_d;
    logic         col_wrap;

    // Next-index computation: column advances, row steps at column wrap.
    always_comb begin
        col_wrap = (col_q == W'(N - 1));
        last_o   = col_wrap && (row_q == W'(N - 1));
        row_d    = row_q;
        col_d    = col_q;
        if (clr_i) begin
            row_d = '0;
            col_d = '0;
        end else if (en_i) begin
            if (col_wrap) begin
                col_d = '0;
                row_d = last_o ? '0 : row_q + W'(1);
            end else begin
                col_d = col_q + W'(1);
            end
        end
    end

    // Index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o = row_q;
    assign col_o = col_q;

endmodule

// File: rtl/fft_trim_ctrl.sv
// Streams a FULL x FULL raster and forwards only the centred SIZE x SIZE
// window through a single registered output stage.
module fft_trim_ctrl
    import fft_trim_pkg::*;
#(
    parameter int SIZE   = 5,
    parameter int DATA_W = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      in_valid,
    input  logic [DATA_W-1:0]         in_data,
    output logic                      in_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic [$clog2(SIZE)-1:0]   out_row,
    output logic [$clog2(SIZE)-1:0]   out_col,
    output logic                      out_last,
    input  logic                      out_ready,
    output logic                      busy,
    output logic                      done
);

    localparam int FULL = full_side(SIZE);
    localparam int OFF  = trim_off(SIZE);
    localparam int CW   = $clog2(FULL);
    localparam int OW   = $clog2(SIZE);

    localparam logic [CW-1:0] FIRST_IDX = CW'(OFF);
    localparam logic [CW-1:0] LAST_IDX  = CW'(OFF + SIZE - 1);

    state_e state_q;
    logic   busy_q;
    logic   done_q;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [OW-1:0]     out_row_q, out_row_d;
    logic [OW-1:0]     out_col_q, out_col_d;
    logic              out_last_q, out_last_d;

    logic [CW-1:0] ri, ci;
    logic [CW-1:0] ri_rel, ci_rel;
    logic          in_last;
    logic          keep;
    logic          in_hs;
    logic          out_hs;
    logic          cnt_clr;

    trim_idx_cnt #(
        .N (FULL),
        .W (CW)
    ) u_idx_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (cnt_clr),
        .en_i   (in_hs),
        .row_o  (ri),
        .col_o  (ci),
        .last_o (in_last)
    );

    // Keep/discard classification and handshake qualification.
    always_comb begin
        keep     = (ri >= FIRST_IDX) && (ri <= LAST_IDX) &&
                   (ci >= FIRST_IDX) && (ci <= LAST_IDX);
        in_ready = (state_q == STREAM) && (!keep || !out_valid_q || out_ready);
        in_hs    = in_valid && in_ready;
        out_hs   = out_valid_q && out_ready;
        cnt_clr  = (state_q == IDLE) && start;
        ri_rel   = ri - FIRST_IDX;
        ci_rel   = ci - FIRST_IDX;
    end

    // Output stage next state: a kept load wins over draining the register.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_row_d   = out_row_q;
        out_col_d   = out_col_q;
        out_last_d  = out_last_q;
        if (in_hs && keep) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data;
            out_row_d   = ri_rel[OW-1:0];
            out_col_d   = ci_rel[OW-1:0];
            out_last_d  = (ri == LAST_IDX) && (ci == LAST_IDX);
        end else if (out_hs) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    // Output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
            out_last_q  <= out_last_d;
        end
    end

    // Frame FSM with registered busy/done. In DRAIN the output register can
    // only hold the final kept element, so an empty register means it is gone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= STREAM;
                        busy_q  <= 1'b1;
                    end
                end
                STREAM: begin
                    if (in_hs && in_last) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!out_valid_q || out_hs) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_row   = out_row_q;
    assign out_col   = out_col_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_fft_trim_ctrl.sv
// Directed scoreboard bench for fft_trim_ctrl at SIZE=5 and SIZE=3.
module tb_fft_trim_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        sel;
    logic        start_d;
    logic        in_valid_d;
    logic [31:0] in_data_d;
    logic        out_ready_d;

    logic        start5, in_valid5, in_ready5, out_valid5, out_last5, busy5, done5;
    logic [31:0] out_data5;
    logic [2:0]  out_row5, out_col5;
    logic        start3, in_valid3, in_ready3, out_valid3, out_last3, busy3, done3;
    logic [31:0] out_data3;
    logic [1:0]  out_row3, out_col3;

    assign start5    = start_d & ~sel;
    assign in_valid5 = in_valid_d & ~sel;
    assign start3    = start_d & sel;
    assign in_valid3 = in_valid_d & sel;

    fft_trim_ctrl #(.SIZE(5), .DATA_W(32)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .start(start5), .in_valid(in_valid5),
        .in_data(in_data_d), .in_ready(in_ready5), .out_valid(out_valid5),
        .out_data(out_data5), .out_row(out_row5), .out_col(out_col5),
        .out_last(out_last5), .out_ready(out_ready_d), .busy(busy5), .done(done5)
    );

    fft_trim_ctrl #(.SIZE(3), .DATA_W(32)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .in_valid(in_valid3),
        .in_data(in_data_d), .in_ready(in_ready3), .out_valid(out_valid3),
        .out_data(out_data3), .out_row(out_row3), .out_col(out_col3),
        .out_last(out_last3), .out_ready(out_ready_d), .busy(busy3), .done(done3)
    );

    logic        m_in_ready, m_out_valid, m_out_last, m_busy, m_done;
    logic [31:0] m_out_data;
    logic [2:0]  m_out_row, m_out_col;

    assign m_in_ready  = sel ? in_ready3  : in_ready5;
    assign m_out_valid = sel ? out_valid3 : out_valid5;
    assign m_out_data  = sel ? out_data3  : out_data5;
    assign m_out_row   = sel ? {1'b0, out_row3} : out_row5;
    assign m_out_col   = sel ? {1'b0, out_col3} : out_col5;
    assign m_out_last  = sel ? out_last3  : out_last5;
    assign m_busy      = sel ? busy3      : busy5;
    assign m_done      = sel ? done3      : done5;

    int checks   = 0;
    int failures = 0;
    logic [38:0] exp_q[$];
    bit          streaming = 1'b0;
    bit          accepted  = 1'b0;
    bit          prev_stall = 1'b0;
    logic [38:0] prev_obs = '0;
    int done_cnt = 0;
    int out_cnt  = 0;
    int cur_size = 5;
    int cur_full = 9;
    int cur_off  = 2;
    int ready_mode = 0;
    int cyc = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic bit is_kept(input int k);
        int r, c;
        r = k / cur_full;
        c = k % cur_full;
        return (r >= cur_off) && (r < cur_off + cur_size) &&
               (c >= cur_off) && (c < cur_off + cur_size);
    endfunction

    function automatic logic [38:0] exp_vec(input int k);
        int r, c;
        logic lst;
        r   = k / cur_full;
        c   = k % cur_full;
        lst = (r == cur_off + cur_size - 1) && (c == cur_off + cur_size - 1);
        return {32'(k), 3'(r - cur_off), 3'(c - cur_off), lst};
    endfunction

    // Sampling point between edges: output scoreboard, stall hold, in_ready, done count.
    task automatic monitor();
        logic [38:0] obs;
        bit stall;
        obs = {m_out_data, m_out_row, m_out_col, m_out_last};
        if (prev_stall) check("stall_hold", {m_out_valid, obs}, {1'b1, prev_obs});
        if (m_out_valid && out_ready_d) begin
            out_cnt++;
            if (exp_q.size() == 0) check("unexpected_out", 64'(exp_q.size()), 64'(1));
            else check("out_elem", obs, exp_q.pop_front());
        end
        if (in_valid_d && streaming) begin
            stall = m_out_valid && !out_ready_d;
            check("in_ready", m_in_ready, stall ? !is_kept(int'(in_data_d)) : 1'b1);
            if (m_in_ready) begin
                accepted = 1'b1;
                if (is_kept(int'(in_data_d))) exp_q.push_back(exp_vec(int'(in_data_d)));
            end
        end else if (in_valid_d) begin
            check("in_ready_idle", m_in_ready, 0);
        end
        if (m_done) done_cnt++;
        prev_stall = m_out_valid && !out_ready_d;
        prev_obs   = obs;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
        out_ready_d = (ready_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
    endtask

    task automatic run_frame(input int sz, input int mode, input int start_at, input int abort_at);
        int d0, o0, n;
        sel        = (sz == 3);
        cur_size   = sz;
        cur_full   = 2 * sz - 1;
        cur_off    = (sz - 1) - (sz - 1) / 2;
        ready_mode = mode;
        n          = cur_full * cur_full;
        d0         = done_cnt;
        o0         = out_cnt;
        start_d = 1'b1;
        tick();
        start_d = 1'b0;
        check("busy_after_start", m_busy, 1);
        streaming = 1'b1;
        for (int k = 0; k < n; k++) begin
            if (k == abort_at) begin
                in_valid_d = 1'b0;
                rst_n      = 1'b0;
                #1;
                check("abort_out_valid", m_out_valid, 0);
                check("abort_busy", m_busy, 0);
                check("abort_in_ready", m_in_ready, 0);
                streaming  = 1'b0;
                exp_q.delete();
                prev_stall = 1'b0;
                tick();
                tick();
                rst_n = 1'b1;
                tick();
                tick();
                check("abort_no_done", 64'(done_cnt - d0), 64'(0));
                return;
            end
            in_valid_d = 1'b1;
            in_data_d  = 32'(k);
            start_d    = (k == start_at);
            accepted   = 1'b0;
            for (int w = 0; w < 20 && !accepted; w++) begin
                tick();
                start_d = 1'b0;
            end
            if (!accepted) begin
                check("accept_timeout", 64'(accepted), 64'(1));
                break;
            end
        end
        in_valid_d = 1'b0;
        streaming  = 1'b0;
        for (int w = 0; w < 50 && done_cnt == d0; w++) tick();
        for (int w = 0; w < 5; w++) tick();
        check("done_count", 64'(done_cnt - d0), 64'(1));
        check("out_count", 64'(out_cnt - o0), 64'(sz * sz));
        check("queue_empty", 64'(exp_q.size()), 64'(0));
        check("busy_idle", m_busy, 0);
    endtask

    initial begin
        rst_n       = 1'b0;
        sel         = 1'b0;
        start_d     = 1'b0;
        in_valid_d  = 1'b0;
        in_data_d   = '0;
        out_ready_d = 1'b1;
        #1;
        check("rst5_outs", {out_valid5, out_data5, out_row5, out_col5, out_last5, busy5, done5, in_ready5}, 64'(0));
        check("rst3_outs", {out_valid3, out_data3, out_row3, out_col3, out_last3, busy3, done3, in_ready3}, 64'(0));
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        // Input offered while idle must be refused.
        in_valid_d = 1'b1;
        in_data_d  = 32'd5;
        tick();
        in_valid_d = 1'b0;
        check("idle_busy", m_busy, 0);

        run_frame(5, 0, -1, -1);
        run_frame(5, 1, -1, -1);
        run_frame(3, 0, -1, -1);
        run_frame(3, 1, -1, -1);
        run_frame(5, 0, 40, -1);
        run_frame(5, 1, -1, 50);
        run_frame(5, 0, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fft_trim_ctrl.md
FFT_TRIM_CTRL -- requirements
Module: fft_trim_ctrl

Interface
REQ-001 SHALL have parameter SIZE, default 5, meaning the side of the trimmed output window; SIZE >= 2.
REQ-002 SHALL have parameter DATA_W, default 32, meaning the element width.
REQ-003 SHALL have derived constants FULL = 2*SIZE-1 (input array side) and OFF = (SIZE-1)-(SIZE-1)/2 (first kept row/col index); these are not overridable.
REQ-004 SHALL have ports in this order:
  clk  in  1  sole clock; all state updates on the rising edge.
  rst_n  in  1  asynchronous, active-low reset.
  start  in  1  single-cycle pulse that begins one frame.
  in_valid  in  1  input element valid.
  in_data  in  DATA_W  input element, raster order (row-major, FULL x FULL).
  in_ready  out  1  input element accepted when in_valid && in_ready.
  out_valid  out  1  trimmed element valid.
  out_data  out  DATA_W  trimmed element.
  out_row  out  $clog2(SIZE)  output row index, 0..SIZE-1.
  out_col  out  $clog2(SIZE)  output column index, 0..SIZE-1.
  out_last  out  1  high with the final (SIZE-1, SIZE-1) element.
  out_ready  in  1  downstream accepts when out_valid && out_ready.
  busy  out  1  high from the cycle after accepted start until the cycle done is asserted.
  done  out  1  single-cycle pulse after the last trimmed element has been handed off.

Function
REQ-005 SHALL implement FSM states IDLE, STREAM, DRAIN, DONE; start is accepted only in IDLE (IDLE->STREAM), and start in any other state is ignored.
REQ-006 SHALL, on the IDLE->STREAM transition, clear input row/col counters (ri, ci) to 0.
REQ-007 SHALL advance ci on every input handshake, wrapping FULL-1->0 and incrementing ri at the wrap.
REQ-008 SHALL classify the element at (ri, ci) as kept iff OFF <= ri < OFF+SIZE and OFF <= ci < OFF+SIZE; otherwise it is discarded.
REQ-009 SHALL drive in_ready = (state==STREAM) && (discarded || !out_valid || out_ready), combinationally.
REQ-010 SHALL accept discarded elements without producing output and without stalling.
REQ-011 SHALL load a kept element into a single output register, so that out_valid rises on the cycle after the handshake (latency 1), with out_row = ri-OFF and out_col = ci-OFF.
REQ-012 SHALL hold out_data, out_row, out_col and out_last stable while out_valid && !out_ready.
REQ-013 SHALL allow a simultaneous output handshake and kept-input load in one cycle (full throughput, no bubble).
REQ-014 SHALL transition STREAM->DRAIN on acceptance of input (FULL-1, FULL-1).
REQ-015 SHALL transition DRAIN->DONE when the out_last handshake completes, or immediately if it completed in the same cycle as the final input.
REQ-016 SHALL assert done for exactly one cycle in DONE, then return to IDLE.
REQ-017 SHALL hold in_ready low in IDLE, DRAIN and DONE; in_valid in those states is ignored.

Reset
REQ-018 SHALL, while rst_n is low and regardless of clk, force state=IDLE, counters=0, out_valid=0, out_last=0, done=0, busy=0, out_data=0, out_row=0 and out_col=0.
REQ-019 SHALL abandon a frame when reset asserts mid-frame, producing no done; the next frame requires a new start.

Structure
REQ-020 SHALL place the FSM state enum and a function computing OFF from SIZE in package fft_trim_pkg.
REQ-021 SHALL instantiate one sub-module, trim_idx_cnt, a parameterised row/col raster counter with clear, enable and wrap.

Verification
REQ-022 SIZE=5, 81 inputs with data 0..80, out_ready=1 -> 25 outputs 20,21,22,23,24,29..60 in order; out_last with 60 at (4,4); done exactly once.
REQ-023 SIZE=5, out_ready toggling 1-of-3 cycles -> identical 25-value sequence; outputs stable while stalled; in_ready low only at kept positions while stalled.
REQ-024 SIZE=3, 25 inputs 0..24 -> outputs 6,7,8,11,12,13,16,17,18; OFF=1.
REQ-025 start pulsed at input 40 of a SIZE=5 frame -> ignored; frame completes normally with one done.
REQ-026 rst_n low after 50 inputs -> out_valid=0 and busy=0 immediately; no done; a fresh start plus 81 inputs yields the full correct 25 outputs.
